// File: rtl/cyq_sipo_pkg.sv
// -----------------------------------------------------------------------------
// cyq_sipo_pkg
// Shared definitions for the cyq_sipo_rx serial-in / parallel-out receiver.
//   - CYQ_SIPO_DEFAULT_WIDTH : default number of data bits per frame
//   - cyq_state_e            : one-hot 4-bit FSM state encoding
//   - is_busy_state()        : decodes which states count as "frame in progress"
// Optional feature macro used by the design: CYQ_SIPO_RX_PARITY_EN.
// -----------------------------------------------------------------------------
package cyq_sipo_pkg;

  localparam int CYQ_SIPO_DEFAULT_WIDTH = 8;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_PAR   = 4'b0100,
    ST_DONE  = 4'b1000
  } cyq_state_e;

  // A frame is "in progress" while data or the parity bit is still expected.
  function automatic logic is_busy_state(input cyq_state_e s);
    return (s == ST_SHIFT) || (s == ST_PAR);
  endfunction

endpackage

// File: rtl/cyq_sipo_shreg.sv
// -----------------------------------------------------------------------------
// cyq_sipo_shreg
// Shift register plus bit counter for the cyq_sipo_rx receiver.
// Bits enter at the LSB and move toward the MSB, so the first sampled bit ends
// up in word[WIDTH-1] once WIDTH bits have been taken.
// Ports:
//   clk          : clock, rising edge
//   srst         : synchronous active-high reset (clears word and counter)
//   clear        : synchronous clear at frame start (priority over shift_en)
//   shift_en     : take one bit from ds this cycle
//   ds           : serial data in
//   at_last      : counter says the next sample completes the data word
//   word_shifted : word as it will look after shifting ds in (used so the
//                  final bit can be committed to Q on the same edge)
//   word         : (CYQ_SIPO_RX_PARITY_EN only) the stored word
// -----------------------------------------------------------------------------
module cyq_sipo_shreg
  import cyq_sipo_pkg::*;
#(
  parameter int WIDTH = CYQ_SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             ds,
  output logic             at_last,
`ifdef CYQ_SIPO_RX_PARITY_EN
  output logic [WIDTH-1:0] word,
`endif
  output logic [WIDTH-1:0] word_shifted
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    if (clear) begin
      word_d  = '0;
      count_d = '0;
    end else if (shift_en && (count_q != CW'(WIDTH))) begin
      // Saturate at WIDTH: the counter must never wrap inside a frame.
      word_d  = {word_q[WIDTH-2:0], ds};
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      word_q  <= '0;
      count_q <= '0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign at_last      = (count_q == CW'(WIDTH - 1));
  assign word_shifted = {word_q[WIDTH-2:0], ds};
`ifdef CYQ_SIPO_RX_PARITY_EN
  assign word         = word_q;
`endif

endmodule

// File: rtl/cyq_sipo_rx.sv
// -----------------------------------------------------------------------------
// cyq_sipo_rx
// Framed serial-to-parallel receiver. Start (in IDLE) opens a frame; WIDTH bits
// are then sampled from Ds on En=1 cycles, MSB first. One cycle after the last
// sample, Q carries the word and Valid pulses for that single (DONE) cycle.
// Optional feature: define CYQ_SIPO_RX_PARITY_EN to add a PAR state that
// samples one even-parity bit after the data; Err then flags a parity error in
// the DONE cycle. Without it Err is constant 0.
// Ports:
//   Clk   : clock, rising edge
//   Reset : synchronous active-high reset
//   Start : frame-start strobe (looked at only in IDLE)
//   En    : sample enable for Ds
//   Ds    : serial data, MSB first
//   Q     : last complete word (registered, held between frames)
//   Valid : one-cycle pulse with each new Q
//   Busy  : high while a frame is being shifted in (SHIFT / PAR)
//   Err   : parity error, meaningful only with Valid
// WIDTH is intended for 2..16.
// -----------------------------------------------------------------------------
module cyq_sipo_rx
  import cyq_sipo_pkg::*;
#(
  parameter int WIDTH = CYQ_SIPO_DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             En,
  input  logic             Ds,
  output logic [WIDTH-1:0] Q,
  output logic             Valid,
  output logic             Busy,
  output logic             Err
);

  cyq_state_e       state_q;
  cyq_state_e       state_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             valid_q;
  logic             valid_d;
  logic             busy_q;
  logic             busy_d;

  logic             sh_clear;
  logic             sh_shift_en;
  logic             sh_at_last;
  logic [WIDTH-1:0] sh_word_shifted;
`ifdef CYQ_SIPO_RX_PARITY_EN
  logic [WIDTH-1:0] sh_word;
  logic             err_q;
  logic             err_d;
`endif

  cyq_sipo_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk          (Clk),
    .srst         (Reset),
    .clear        (sh_clear),
    .shift_en     (sh_shift_en),
    .ds           (Ds),
    .at_last      (sh_at_last),
`ifdef CYQ_SIPO_RX_PARITY_EN
    .word         (sh_word),
`endif
    .word_shifted (sh_word_shifted)
  );

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    valid_d     = 1'b0;
    sh_clear    = 1'b0;
    sh_shift_en = 1'b0;
`ifdef CYQ_SIPO_RX_PARITY_EN
    err_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          sh_clear = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (En) begin
          sh_shift_en = 1'b1;
          if (sh_at_last) begin
`ifdef CYQ_SIPO_RX_PARITY_EN
            state_d = ST_PAR;
`else
            // Commit the word including the bit being sampled right now, so
            // Q and Valid show up in the very next cycle.
            state_d = ST_DONE;
            q_d     = sh_word_shifted;
            valid_d = 1'b1;
`endif
          end
        end
      end
`ifdef CYQ_SIPO_RX_PARITY_EN
      ST_PAR: begin
        if (En) begin
          state_d = ST_DONE;
          q_d     = sh_word;
          valid_d = 1'b1;
          // Even parity: data bits plus parity bit must XOR to zero.
          err_d   = ^{sh_word, Ds};
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = is_busy_state(state_d);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef CYQ_SIPO_RX_PARITY_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  assign Q     = q_q;
  assign Valid = valid_q;
  assign Busy  = busy_q;

endmodule

// File: tb/tb_cyq_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_cyq_sipo_rx
// Directed bench for cyq_sipo_rx (WIDTH=8). A frame-level reference model
// (bit list -> word, counted against the frame length) predicts Q/Valid/Busy/
// Err after every clock edge; a few literal expectations pin the scenarios.
// -----------------------------------------------------------------------------
module tb_cyq_sipo_rx;

  localparam int WIDTH = 8;
`ifdef CYQ_SIPO_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic             En = 1'b0;
  logic             Ds = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             Valid;
  logic             Busy;
  logic             Err;

  always #5 Clk = ~Clk;

  cyq_sipo_rx #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .En    (En),
    .Ds    (Ds),
    .Q     (Q),
    .Valid (Valid),
    .Busy  (Busy),
    .Err   (Err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: is a frame open, how many bits were taken, the
  // bits collected so far, and whether the DONE cycle is coming up.
  bit               m_open;
  bit               m_done_next;
  int               m_n;
  logic [WIDTH-1:0] m_word;
  logic             m_par;
  logic [WIDTH-1:0] exp_q;
  logic             exp_valid;
  logic             exp_busy;
  logic             exp_err;

  // Per-scenario bookkeeping.
  int               step_no;
  int               valid_cnt;
  int               busy_cnt;
  int               valid_step;
  logic [WIDTH-1:0] q_log [0:3];
  logic             err_log [0:3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic e, input logic d);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (r) begin
      m_open      = 1'b0;
      m_done_next = 1'b0;
      m_n         = 0;
      m_word      = '0;
      exp_q       = '0;
    end else if (m_done_next) begin
      m_done_next = 1'b0;           // DONE cycle: inputs are ignored
    end else if (!m_open) begin
      if (s) begin
        m_open = 1'b1;
        m_n    = 0;
        m_word = '0;
      end
    end else if (e) begin
      if (m_n < WIDTH) m_word[WIDTH-1-m_n] = d;
      else             m_par = d;
      m_n++;
      if (m_n == WIDTH + PAR_BITS) begin
        m_open      = 1'b0;
        m_done_next = 1'b1;
        exp_q       = m_word;
        exp_valid   = 1'b1;
        exp_err     = (PAR_BITS != 0) ? ((^m_word) ^ m_par) : 1'b0;
      end
    end
    exp_busy = m_open;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic r, input logic s, input logic e, input logic d);
    Reset = r;
    Start = s;
    En    = e;
    Ds    = d;
    model_step(r, s, e, d);
    @(posedge Clk);
    #1;
    step_no++;
    chk("q",     Q,     exp_q);
    chk("valid", Valid, exp_valid);
    chk("busy",  Busy,  exp_busy);
    chk("err",   Err,   exp_err);
    if (Valid) begin
      if (valid_cnt < 4) begin
        q_log[valid_cnt]   = Q;
        err_log[valid_cnt] = Err;
      end
      valid_cnt++;
      valid_step = step_no;
      $display("rx word: q=%02h err=%0d step=%0d", Q, Err, step_no);
    end
    if (Busy) busy_cnt++;
  endtask

  task automatic begin_scn(input string name);
    step_no    = 0;
    valid_cnt  = 0;
    busy_cnt   = 0;
    valid_step = -1;
    $display("scenario: %s", name);
  endtask

  // Start, then the 8 data bits MSB first (with optional stall and a stray
  // Start), then the even-parity bit when parity is built in.
  task automatic send_frame(input logic [7:0] w, input int stall_before, input int stall_len,
                            input int start_at);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_before) begin
        for (int k = 0; k < stall_len; k++) cycle(1'b0, 1'b0, 1'b0, ~w[7-i]);
      end
      cycle(1'b0, (i == start_at), 1'b1, w[7-i]);
    end
    if (PAR_BITS != 0) cycle(1'b0, 1'b0, 1'b1, ^w);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b1, k[0]);
  endtask

  initial begin
    begin_scn("reset");
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_q", Q, 32'h0);
    chk("reset_busy", Busy, 32'h0);

    begin_scn("plain frame B2");
    send_frame(8'hB2, -1, 0, -1);
    idle(3);
    chk("a_q", Q, 32'hB2);
    chk("a_valid_cnt", valid_cnt, 1);
    chk("a_busy_cnt", busy_cnt, 8 + PAR_BITS);
    chk("a_latency", valid_step, 9 + PAR_BITS);

    begin_scn("stalled frame B2");
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    begin_scn("stalled frame B2");
    send_frame(8'hB2, 4, 3, -1);
    idle(3);
    chk("b_q", Q, 32'hB2);
    chk("b_valid_cnt", valid_cnt, 1);
    chk("b_latency", valid_step, 12 + PAR_BITS);

    begin_scn("start during bit 5");
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("c_q_cleared", Q, 32'h0);
    begin_scn("start during bit 5");
    send_frame(8'hB2, -1, 0, 4);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);   // Start in the DONE cycle is ignored
    idle(4);
    chk("c_q", Q, 32'hB2);
    chk("c_valid_cnt", valid_cnt, 1);
    chk("c_latency", valid_step, 9 + PAR_BITS);

    begin_scn("reset mid-frame");
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("d_busy_after_reset", Busy, 32'h0);
    idle(12);
    chk("d_q", Q, 32'h0);
    chk("d_valid_cnt", valid_cnt, 0);

    begin_scn("back-to-back FF then 01");
    send_frame(8'hFF, -1, 0, -1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);   // DONE cycle
    send_frame(8'h01, -1, 0, -1);    // Start lands in the cycle after DONE
    idle(3);
    chk("e_valid_cnt", valid_cnt, 2);
    chk("e_q0", q_log[0], 32'hFF);
    chk("e_q1", q_log[1], 32'h01);

`ifdef CYQ_SIPO_RX_PARITY_EN
    begin_scn("parity good / bad");
    send_frame(8'hB2, -1, 0, -1);    // even parity bit for B2 is 0
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, (8'hB2 >> (7 - i)) & 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);   // wrong parity bit
    idle(2);
    chk("f_valid_cnt", valid_cnt, 2);
    chk("f_q0", q_log[0], 32'hB2);
    chk("f_err0", err_log[0], 32'h0);
    chk("f_q1", q_log[1], 32'hB2);
    chk("f_err1", err_log[1], 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cyq_sipo_rx.md
CYQ_SIPO_RX -- requirements
Module: cyq_sipo_rx

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, number of data bits per frame (range 2..16).
REQ-002 The block SHALL have the port Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have the port Reset  input  1  reset; synchronous to Clk and active-high.
REQ-004 The block SHALL have the port Start  input  1  frame-start strobe; sampled only in IDLE.
REQ-005 The block SHALL have the port En  input  1  shift enable, active-high; a bit is sampled only on a cycle with En=1.
REQ-006 The block SHALL have the port Ds  input  1  serial data, MSB of the sender's parallel word first.
REQ-007 The block SHALL have the port Q  output  WIDTH  last complete received word, registered.
REQ-008 The block SHALL have the port Valid  output  1  one-cycle pulse marking a new Q.
REQ-009 The block SHALL have the port Busy  output  1  high while a frame is being shifted in.
REQ-010 The block SHALL have the port Err  output  1  parity-error flag, qualified by Valid.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT, PAR and DONE; PAR exists only per REQ-024.
REQ-012 In IDLE, a cycle with Start=1 SHALL move to SHIFT and clear the bit counter and shift register.
REQ-013 In SHIFT, each cycle with En=1 SHALL sample Ds and increment the bit counter; En=0 SHALL hold all state.
REQ-014 Bit order SHALL be: the k-th sampled bit (k=0 first) lands in Q[WIDTH-1-k], so the first bit is the MSB.
REQ-015 After the WIDTH-th sample, the next state SHALL be PAR (macro defined) or DONE (macro undefined).
REQ-016 In DONE, Q SHALL load the assembled word and Valid SHALL be 1 for exactly that cycle; the next state SHALL be IDLE.
REQ-017 Latency SHALL be one cycle: Valid and the new Q appear in the cycle after the final sampled bit.
REQ-018 Q SHALL hold its value between DONE cycles; partial frames SHALL never reach Q.
REQ-019 Start SHALL be ignored in SHIFT, PAR and DONE; a frame is never restarted or aborted by Start.
REQ-020 Busy SHALL be 1 in SHIFT and PAR and 0 in IDLE and DONE.
REQ-021 Bit counter width SHALL be clog2(WIDTH+1); no wrap-around is permitted within a frame.

Reset
REQ-022 Reset=1 at a rising edge SHALL force IDLE from any state and clear the counter, the shift register, Q, Valid, Busy and Err to 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; no Valid pulse SHALL follow until a new Start.

Configuration
REQ-024 The macro CYQ_SIPO_RX_PARITY_EN, when defined, SHALL add state PAR, which samples one even-parity bit on the next En=1 cycle after the data bits.
REQ-025 With the macro defined, Err SHALL equal the XOR of the WIDTH data bits and the parity bit in the DONE cycle, and 0 otherwise.
REQ-026 Without the macro, PAR and the parity logic SHALL be absent and Err SHALL be tied to 0.

Structure
REQ-027 A shared package cyq_sipo_pkg SHALL hold the state encoding constants (one-hot, 4 bits) and the default WIDTH.
REQ-028 The shift register and bit counter SHALL form one sub-module, cyq_sipo_shreg; the FSM and the output registers SHALL stay in the top module.

Verification
REQ-029 The bench SHALL cover this scenario: with WIDTH=8 and no macro, Start, then Ds=1,0,1,1,0,0,1,0 with En=1 -> the next cycle has Q=8'hB2 and Valid=1 for 1 cycle, and Busy=1 for 8 cycles.
REQ-030 The bench SHALL cover this scenario: the same frame with En=0 inserted for 3 cycles after bit 4 -> Q=8'hB2, and Valid arrives 3 cycles later than in REQ-029.
REQ-031 The bench SHALL cover this scenario: Start pulsed again during bit 5 -> the frame is unaffected, Q=8'hB2, and only one Valid pulse occurs.
REQ-032 The bench SHALL cover this scenario: Reset=1 after bit 3, then idle -> Q=0, Valid is never asserted, and Busy=0 on the cycle after Reset.
REQ-033 The bench SHALL cover this scenario: with the macro defined, data 8'hB2 plus parity bit 0 -> Err=0; the same data plus parity bit 1 -> Err=1 with Valid, and Q=8'hB2 in both cases.
REQ-034 The bench SHALL cover this scenario: back-to-back frames 8'hFF and then 8'h01, with Start in the cycle after DONE -> two Valid pulses, Q=8'hFF and then Q=8'h01.
